// File: rtl/iz_param_loader_multi_pkg.sv
// Shared state encodings, reset defaults and frame geometry for the
// Izhikevich parameter loader.
package iz_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HDR      = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_CHECK    = 3'd4;
    localparam logic [2:0] ST_WAIT_LOW = 3'd5;

    function automatic int default_a(input int scale);
        return (scale > 0) ? 1 : 1;
    endfunction

    function automatic int default_b(input int scale);
        return (scale > 0) ? 13 : 13;
    endfunction

    function automatic int default_c(input int scale);
        return -65 * scale;
    endfunction

    function automatic int default_d(input int scale);
        return 2 * scale;
    endfunction

    // bcast + address + four raw fields + parity
    function automatic int frame_len(input int addr_w, input int raw_w);
        return 1 + addr_w + 4 * raw_w + 1;
    endfunction

endpackage

// File: rtl/iz_param_loader_multi_scaler.sv
// Combinational mapping of the raw a/b/c/d fields onto fixed-point neuron
// parameters.
module iz_param_scaler #(
    parameter int RAW_W   = 8,
    parameter int PARAM_W = 16,
    parameter int SCALE   = 64
) (
    input  logic [RAW_W-1:0]   raw_a_i,
    input  logic [RAW_W-1:0]   raw_b_i,
    input  logic [RAW_W-1:0]   raw_c_i,
    input  logic [RAW_W-1:0]   raw_d_i,
    output logic [PARAM_W-1:0] a_o,
    output logic [PARAM_W-1:0] b_o,
    output logic [PARAM_W-1:0] c_o,
    output logic [PARAM_W-1:0] d_o
);

    logic signed [RAW_W-1:0] b_off;
    logic signed [RAW_W-1:0] b_sh;
    logic [6:0]              c_sum;
    logic                    unused_lsbs;

    // Flipping the MSB is the same as subtracting 2^(RAW_W-1) in two's complement.
    assign b_off = {~raw_b_i[RAW_W-1], raw_b_i[RAW_W-2:0]};
    assign b_sh  = b_off >>> (RAW_W - 6);
    assign c_sum = 7'd40 + 7'(raw_c_i[RAW_W-1 -: 5]);

    assign a_o = PARAM_W'(raw_a_i[RAW_W-1 -: 4]) + PARAM_W'(1);
    assign b_o = {{(PARAM_W-RAW_W){b_sh[RAW_W-1]}}, b_sh};
    assign c_o = PARAM_W'(0) - PARAM_W'(c_sum) * PARAM_W'(SCALE);
    assign d_o = PARAM_W'(raw_d_i[RAW_W-1 -: 4]) * PARAM_W'(SCALE);

    assign unused_lsbs = ^{raw_a_i[RAW_W-5:0], raw_c_i[RAW_W-6:0], raw_d_i[RAW_W-5:0]};

endmodule

// File: rtl/iz_param_loader_multi.sv
// Framed serial loader that commits scaled a/b/c/d atomically to one neuron
// or to every neuron on broadcast; bad or aborted frames are dropped.
module iz_param_loader_multi
    import iz_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = $clog2(NUM_NEURONS),
    parameter int RAW_W       = 8,
    parameter int PARAM_W     = 16,
    parameter int SCALE       = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           serial_data_in,
    input  logic                           load_enable,
    output logic [NUM_NEURONS*PARAM_W-1:0] param_a_flat,
    output logic [NUM_NEURONS*PARAM_W-1:0] param_b_flat,
    output logic [NUM_NEURONS*PARAM_W-1:0] param_c_flat,
    output logic [NUM_NEURONS*PARAM_W-1:0] param_d_flat,
    output logic [NUM_NEURONS-1:0]         params_ready,
    output logic                           busy,
    output logic                           commit_pulse,
    output logic                           err_pulse,
    output logic [7:0]                     err_count,
    output logic [2:0]                     load_state
);

    localparam int FRAME_LEN = frame_len(ADDR_W, RAW_W);
    localparam int DATA_W    = FRAME_LEN - ADDR_W - 2;
    localparam int CNT_W     = $clog2(DATA_W + 1);

    logic [2:0]             state_q, state_d;
    logic                   le_prev_q;
    logic                   bcast_q, bcast_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, addr_nx;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   par_q, par_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_NEURONS-1:0] tgt_q, tgt_d, ready_q, ready_d;
    logic                   commit_q, commit_d, err_q, err_d;
    logic [7:0]             errcnt_q, errcnt_d;
    logic                   sample, abort, valid;

    logic [NUM_NEURONS-1:0][PARAM_W-1:0] a_q, b_q, c_q, d_q;
    logic [PARAM_W-1:0]                  sa, sb, sc, sd;

    iz_param_scaler #(.RAW_W(RAW_W), .PARAM_W(PARAM_W), .SCALE(SCALE)) u_scaler (
        .raw_a_i (data_q[DATA_W-1 -: RAW_W]),
        .raw_b_i (data_q[3*RAW_W-1 -: RAW_W]),
        .raw_c_i (data_q[2*RAW_W-1 -: RAW_W]),
        .raw_d_i (data_q[RAW_W-1:0]),
        .a_o     (sa),
        .b_o     (sb),
        .c_o     (sc),
        .d_o     (sd)
    );

    assign sample  = enable && load_enable;
    assign abort   = enable && !load_enable;
    assign addr_nx = ADDR_W'({addr_q, serial_data_in});
    assign valid   = !par_q && (bcast_q || int'(addr_q) < NUM_NEURONS);

    always_comb begin
        state_d  = state_q;
        bcast_d  = bcast_q;
        addr_d   = addr_q;
        data_d   = data_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        ready_d  = ready_q;
        errcnt_d = errcnt_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (sample && !le_prev_q) begin
                bcast_d = serial_data_in;
                par_d   = serial_data_in;
                addr_d  = '0;
                cnt_d   = '0;
                state_d = ST_HDR;
            end
            ST_HDR, ST_DATA, ST_PARITY: begin
                if (abort) begin
                    err_d   = 1'b1;
                    ready_d = '1;
                    state_d = ST_IDLE;
                    if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                end else if (sample) begin
                    par_d = par_q ^ serial_data_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == ST_HDR) begin
                        addr_d = addr_nx;
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            // An out-of-range unicast address selects nobody.
                            for (int k = 0; k < NUM_NEURONS; k++)
                                tgt_d[k] = bcast_q || (int'(addr_nx) == k);
                            ready_d = ready_q & ~tgt_d;
                            cnt_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else if (state_q == ST_DATA) begin
                        data_d = {data_q[DATA_W-2:0], serial_data_in};
                        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_PARITY;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: if (enable) begin
                commit_d = valid;
                err_d    = !valid;
                if (!valid && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                ready_d  = '1;
                state_d  = load_enable ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: if (!load_enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            le_prev_q <= 1'b0;
            bcast_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            cnt_q     <= '0;
            tgt_q     <= '0;
            ready_q   <= '1;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            le_prev_q <= load_enable;
            bcast_q   <= bcast_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            ready_q   <= ready_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
            errcnt_q  <= errcnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                a_q[k] <= PARAM_W'(default_a(SCALE));
                b_q[k] <= PARAM_W'(default_b(SCALE));
                c_q[k] <= PARAM_W'(default_c(SCALE));
                d_q[k] <= PARAM_W'(default_d(SCALE));
            end
        end else if (commit_d) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (tgt_q[k]) begin
                    a_q[k] <= sa;
                    b_q[k] <= sb;
                    c_q[k] <= sc;
                    d_q[k] <= sd;
                end
            end
        end
    end

    assign param_a_flat = a_q;
    assign param_b_flat = b_q;
    assign param_c_flat = c_q;
    assign param_d_flat = d_q;
    assign params_ready = ready_q;
    assign busy         = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                          (state_q == ST_PARITY) || (state_q == ST_CHECK);
    assign commit_pulse = commit_q;
    assign err_pulse    = err_q;
    assign err_count    = errcnt_q;
    assign load_state   = state_q;

endmodule

// File: tb/tb_iz_param_loader_multi.sv
// Directed bench for the serial Izhikevich parameter loader at default sizes.
module tb_iz_param_loader_multi;

    logic        clk = 1'b0;
    logic        reset_n, enable, serial_data_in, load_enable;
    logic [63:0] param_a_flat, param_b_flat, param_c_flat, param_d_flat;
    logic [3:0]  params_ready;
    logic        busy, commit_pulse, err_pulse;
    logic [7:0]  err_count;
    logic [2:0]  load_state;
    int          n_chk = 0;
    int          n_err = 0;

    iz_param_loader_multi dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .serial_data_in (serial_data_in),
        .load_enable    (load_enable),
        .param_a_flat   (param_a_flat),
        .param_b_flat   (param_b_flat),
        .param_c_flat   (param_c_flat),
        .param_d_flat   (param_d_flat),
        .params_ready   (params_ready),
        .busy           (busy),
        .commit_pulse   (commit_pulse),
        .err_pulse      (err_pulse),
        .err_count      (err_count),
        .load_state     (load_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] s16(input int v);
        return v[15:0];
    endfunction

    task automatic chk_neuron(input string tag, input int k, input int a, input int b,
                              input int c, input int d);
        chk($sformatf("%s_n%0d_a", tag, k), 32'(param_a_flat[k*16 +: 16]), 32'(s16(a)));
        chk($sformatf("%s_n%0d_b", tag, k), 32'(param_b_flat[k*16 +: 16]), 32'(s16(b)));
        chk($sformatf("%s_n%0d_c", tag, k), 32'(param_c_flat[k*16 +: 16]), 32'(s16(c)));
        chk($sformatf("%s_n%0d_d", tag, k), 32'(param_d_flat[k*16 +: 16]), 32'(s16(d)));
    endtask

    function automatic logic [35:0] mk(input logic b, input logic [1:0] addr,
                                       input logic [7:0] ra, input logic [7:0] rb,
                                       input logic [7:0] rc, input logic [7:0] rd,
                                       input logic flip);
        logic [34:0] body;
        body = {b, addr, ra, rb, rc, rd};
        return {body, (^body) ^ flip};
    endfunction

    // Drives the first nbits of fr at negedges; leaves load_enable high.
    // At bit pause_at, enable drops for 5 cycles and load_enable glitches low.
    task automatic send(input logic [35:0] fr, input int nbits, input int pause_at);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == pause_at) begin
                enable = 1'b0;
                load_enable = 1'b0;
                repeat (2) @(negedge clk);
                load_enable = 1'b1;
                repeat (3) @(negedge clk);
                enable = 1'b1;
            end
            load_enable = 1'b1;
            serial_data_in = fr[35-i];
        end
    endtask

    initial begin
        int commits;
        reset_n = 1'b0; enable = 1'b1; serial_data_in = 1'b0; load_enable = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) chk_neuron("rst", k, 1, 13, -4160, 128);
        chk("rst_ready", 32'(params_ready), 32'hF);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(load_state), 0);

        // Unicast to neuron 2
        send(mk(1'b0, 2'd2, 8'hF0, 8'hC0, 8'h80, 8'h40, 1'b0), 36, -1);
        @(negedge clk); load_enable = 1'b0;
        chk("u_state_check", 32'(load_state), 4);
        chk("u_busy_check", 32'(busy), 1);
        chk("u_ready_low", 32'(params_ready), 32'hB);
        chk("u_commit_early", 32'(commit_pulse), 0);
        chk_neuron("u_pre", 2, 1, 13, -4160, 128);
        @(negedge clk);
        chk("u_commit", 32'(commit_pulse), 1);
        chk("u_err", 32'(err_pulse), 0);
        chk("u_ready", 32'(params_ready), 32'hF);
        chk_neuron("u", 2, 16, 16, -3584, 256);
        chk_neuron("u", 0, 1, 13, -4160, 128);
        chk_neuron("u", 1, 1, 13, -4160, 128);
        chk_neuron("u", 3, 1, 13, -4160, 128);
        @(negedge clk);
        chk("u_commit_once", 32'(commit_pulse), 0);

        // Same frame, bad parity
        send(mk(1'b0, 2'd2, 8'h10, 8'h10, 8'h10, 8'h10, 1'b1), 36, -1);
        @(negedge clk); load_enable = 1'b0;
        @(negedge clk);
        chk("p_err", 32'(err_pulse), 1);
        chk("p_commit", 32'(commit_pulse), 0);
        chk("p_errcnt", 32'(err_count), 1);
        chk("p_ready", 32'(params_ready), 32'hF);
        chk_neuron("p", 2, 16, 16, -3584, 256);
        @(negedge clk);
        chk("p_err_once", 32'(err_pulse), 0);

        // Broadcast; address field ignored
        send(mk(1'b1, 2'd3, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0), 36, -1);
        @(negedge clk); load_enable = 1'b0;
        chk("b_ready_low", 32'(params_ready), 0);
        chk("b_pre_d0", 32'(param_d_flat[15:0]), 128);
        @(negedge clk);
        chk("b_commit", 32'(commit_pulse), 1);
        for (int k = 0; k < 4; k++) chk_neuron("b", k, 1, -32, -4544, 960);

        // Unicast to neuron 1 with an enable pause and a load_enable glitch
        send(mk(1'b0, 2'd1, 8'h12, 8'h9C, 8'h37, 8'hE5, 1'b0), 36, 10);
        @(negedge clk); load_enable = 1'b0;
        @(negedge clk);
        chk("e_commit", 32'(commit_pulse), 1);
        chk("e_errcnt", 32'(err_count), 1);
        chk_neuron("e", 1, 2, 7, -2944, 896);
        chk_neuron("e", 0, 1, -32, -4544, 960);

        // Abort after 20 bits
        send(mk(1'b0, 2'd0, 8'hAA, 8'h55, 8'hAA, 8'h55, 1'b0), 20, -1);
        @(negedge clk); load_enable = 1'b0;
        @(negedge clk);
        chk("a_state", 32'(load_state), 0);
        chk("a_err", 32'(err_pulse), 1);
        chk("a_commit", 32'(commit_pulse), 0);
        chk("a_errcnt", 32'(err_count), 2);
        chk("a_ready", 32'(params_ready), 32'hF);
        chk_neuron("a", 0, 1, -32, -4544, 960);

        // Envelope held high 10 extra cycles
        send(mk(1'b0, 2'd3, 8'h00, 8'hFF, 8'h08, 8'h10, 1'b0), 36, -1);
        commits = 0;
        repeat (11) begin
            @(negedge clk);
            if (commit_pulse) commits++;
        end
        chk("w_state", 32'(load_state), 5);
        chk("w_busy", 32'(busy), 0);
        chk("w_commits", 32'(commits), 1);
        chk_neuron("w", 3, 1, 31, -2624, 64);
        load_enable = 1'b0;
        @(negedge clk);
        chk("w_idle", 32'(load_state), 0);

        // Asynchronous reset mid-frame
        send(mk(1'b0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0), 10, -1);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) chk_neuron("r", k, 1, 13, -4160, 128);
        chk("r_state", 32'(load_state), 0);
        chk("r_errcnt", 32'(err_count), 0);
        chk("r_ready", 32'(params_ready), 32'hF);
        chk("r_busy", 32'(busy), 0);
        @(negedge clk); load_enable = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        chk("r_after", 32'(load_state), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

endmodule
